// File: rtl/aes_pkg.sv
// Shared AES types, constants and GF(2^8) byte/column helpers for the iterative cipher.
package aes_pkg;

    localparam int   NR           = 10;
    localparam logic AES_MODE_ENC = 1'b0;
    localparam logic AES_MODE_DEC = 1'b1;

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} aes_ctrl_state_t;
    typedef logic [127:0] aes_block_t;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // Multiplicative inverse as a^254 (maps 0 to 0, as the S-box requires).
    function automatic logic [7:0] ginv(input logic [7:0] a);
        logic [7:0] r;
        r = a;
        for (int i = 0; i < 6; i++) r = gmul(gmul(r, r), a);
        return gmul(r, r);
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] b;
        b = ginv(a);
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [7:0] invSbox(input logic [7:0] a);
        return ginv({a[6:0], a[7]} ^ {a[4:0], a[7:5]} ^ {a[1:0], a[7:2]} ^ 8'h05);
    endfunction

    function automatic logic [31:0] mixColumn(input logic [31:0] col);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = col;
        return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    endfunction

    function automatic logic [31:0] invMixColumn(input logic [31:0] col);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = col;
        return {gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09),
                gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d),
                gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b),
                gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e)};
    endfunction

endpackage

// File: rtl/aes_round.sv
// One combinational AES round (forward, plus inverse when AES_CTRL_DECRYPT_EN is defined).
// Byte i of a block sits at [127-8*i -: 8]; byte 4*c+r is row r of column c.
module aes_round
    import aes_pkg::*;
(
    input  aes_block_t state,
    input  aes_block_t key,
    input  logic       inv,
    input  logic       finalRound,
    output aes_block_t out
);

    aes_block_t encShifted;
    aes_block_t encMixed;
    aes_block_t encOut;

    // SubBytes and ShiftRows fused: each output byte reads its shifted source directly.
    always_comb begin
        encShifted = '0;
        encMixed   = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                encShifted[127-8*(4*c+r) -: 8] = sbox(state[127-8*(4*((c+r)%4)+r) -: 8]);
            end
        end
        for (int c = 0; c < 4; c++) begin
            encMixed[127-32*c -: 32] = mixColumn(encShifted[127-32*c -: 32]);
        end
        encOut = (finalRound ? encShifted : encMixed) ^ key;
    end

`ifdef AES_CTRL_DECRYPT_EN
    aes_block_t decShifted;
    aes_block_t decAdded;
    aes_block_t decMixed;

    always_comb begin
        decShifted = '0;
        decMixed   = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                decShifted[127-8*(4*c+r) -: 8] = invSbox(state[127-8*(4*((c-r+4)%4)+r) -: 8]);
            end
        end
        decAdded = decShifted ^ key;
        for (int c = 0; c < 4; c++) begin
            decMixed[127-32*c -: 32] = invMixColumn(decAdded[127-32*c -: 32]);
        end
    end

    assign out = inv ? (finalRound ? decAdded : decMixed) : encOut;
`else
    logic unusedInv;
    assign unusedInv = inv;
    assign out = encOut;
`endif

endmodule

// File: rtl/aes_round_controller.sv
// Iterative AES-128 controller: one round per clock on a shared aes_round datapath.
// Define AES_CTRL_DECRYPT_EN to honour in_mode and build the inverse round path.
module aes_round_controller #(
    parameter int NR = aes_pkg::NR
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         in_mode,
    input  logic [127:0] in_block,
    output logic [3:0]   rk_idx,
    input  logic [127:0] rk_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_block,
    output logic         busy
);
    import aes_pkg::*;

    aes_ctrl_state_t fsmQ;
    aes_block_t      state_q;
    logic [3:0]      round_q;
    logic            mode_q;
    logic            modeIn;
    logic            lastRound;
    aes_block_t      roundOut;

`ifdef AES_CTRL_DECRYPT_EN
    assign modeIn = in_mode;
`else
    logic unusedMode;
    assign unusedMode = in_mode;
    assign modeIn     = AES_MODE_ENC;
`endif

    assign lastRound = (round_q == 4'(NR));

    aes_round uRound (
        .state      (state_q),
        .key        (rk_in),
        .inv        (mode_q),
        .finalRound (lastRound),
        .out        (roundOut)
    );

    assign in_ready  = (fsmQ == IDLE);
    assign out_valid = (fsmQ == DONE);
    assign busy      = (fsmQ == RUN) || (fsmQ == DONE);
    assign out_block = state_q;

    // Decryption walks the key schedule backwards, starting from the last round key.
    always_comb begin
        rk_idx = 4'd0;
        case (fsmQ)
            IDLE:    rk_idx = (modeIn == AES_MODE_DEC) ? 4'(NR) : 4'd0;
            RUN:     rk_idx = (mode_q == AES_MODE_DEC) ? 4'(NR) - round_q : round_q;
            default: rk_idx = 4'd0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsmQ    <= IDLE;
            state_q <= '0;
            round_q <= '0;
            mode_q  <= AES_MODE_ENC;
        end else if (clr) begin
            fsmQ    <= IDLE;
            round_q <= '0;
        end else begin
            case (fsmQ)
                IDLE: begin
                    if (in_valid) begin
                        state_q <= in_block ^ rk_in;
                        mode_q  <= modeIn;
                        round_q <= 4'd1;
                        fsmQ    <= RUN;
                    end
                end
                RUN: begin
                    state_q <= roundOut;
                    if (lastRound) fsmQ <= DONE;
                    else           round_q <= round_q + 4'd1;
                end
                DONE: begin
                    if (out_ready) fsmQ <= IDLE;
                end
                default: fsmQ <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_aes_round_controller.sv
// Directed bench for aes_round_controller using the FIPS-197 C.1 AES-128 vectors.
module tb_aes_round_controller;

    localparam logic [127:0] PT = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         clr = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic         in_mode = 1'b0;
    logic [127:0] in_block = '0;
    logic [3:0]   rk_idx;
    logic [127:0] rk_in;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [127:0] out_block;
    logic         busy;

    int total = 0;
    int passed = 0;
    int failed = 0;

    always #5 clk = ~clk;

    // Expanded key schedule for key 000102...0f.
    function automatic logic [127:0] roundKey(input logic [3:0] i);
        case (i)
            4'd0:    return 128'h000102030405060708090a0b0c0d0e0f;
            4'd1:    return 128'hd6aa74fdd2af72fadaa678f1d6ab76fe;
            4'd2:    return 128'hb692cf0b643dbdf1be9bc5006830b3fe;
            4'd3:    return 128'hb6ff744ed2c2c9bf6c590cbf0469bf41;
            4'd4:    return 128'h47f7f7bc95353e03f96c32bcfd058dfd;
            4'd5:    return 128'h3caaa3e8a99f9deb50f3af57adf622aa;
            4'd6:    return 128'h5e390f7df7a69296a7553dc10aa31f6b;
            4'd7:    return 128'h14f9701ae35fe28c440adf4d4ea9c026;
            4'd8:    return 128'h47438735a41c65b9e016baf4aebf7ad2;
            4'd9:    return 128'h549932d1f08557681093ed9cbe2c974e;
            4'd10:   return 128'h13111d7fe3944a17f307a78b4d2b30c5;
            default: return 128'h0;
        endcase
    endfunction

    assign rk_in = roundKey(rk_idx);

    aes_round_controller dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (clr),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_mode   (in_mode),
        .in_block  (in_block),
        .rk_idx    (rk_idx),
        .rk_in     (rk_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_block (out_block),
        .busy      (busy)
    );

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic startBlock(input logic m, input logic [127:0] blk);
        in_valid = 1'b1;
        in_mode  = m;
        in_block = blk;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic waitDone(output int n);
        n = 0;
        while (!out_valid && n < 30) begin
            tick();
            n++;
        end
    endtask

    task automatic drain();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic checkResetOutputs(input string tag);
        check({tag, "_in_ready"}, 128'(in_ready), 128'd1);
        check({tag, "_out_valid"}, 128'(out_valid), 128'd0);
        check({tag, "_out_block"}, out_block, 128'd0);
        check({tag, "_busy"}, 128'(busy), 128'd0);
        check({tag, "_rk_idx"}, 128'(rk_idx), 128'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        bit sawValid;

        #1;
        checkResetOutputs("reset");
        #11 rst_n = 1'b1;
        tick();

        // FIPS-197 C.1 encrypt with latency measurement
        in_mode = 1'b0;
        #1;
        check("enc_idle_rk_idx", 128'(rk_idx), 128'd0);
        startBlock(1'b0, PT);
        check("enc_busy", 128'(busy), 128'd1);
        check("enc_in_ready_low", 128'(in_ready), 128'd0);
        check("enc_rk_idx_r1", 128'(rk_idx), 128'd1);
        waitDone(n);
        check("enc_latency", 128'(n), 128'd10);
        check("enc_out_block", out_block, CT);
        check("enc_done_rk_idx", 128'(rk_idx), 128'd0);

        // Backpressure in DONE with a second block waiting
        in_valid = 1'b1;
        in_mode  = 1'b0;
        in_block = PT;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_out_valid", 128'(out_valid), 128'd1);
            check("bp_out_block", out_block, CT);
            check("bp_in_ready", 128'(in_ready), 128'd0);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("bp_idle_in_ready", 128'(in_ready), 128'd1);
        check("bp_idle_out_valid", 128'(out_valid), 128'd0);
        tick();
        in_valid = 1'b0;
        check("bp_second_accepted", 128'(busy), 128'd1);
        check("bp_second_rk_idx", 128'(rk_idx), 128'd1);
        waitDone(n);
        check("bp_second_latency", 128'(n), 128'd10);
        check("bp_second_block", out_block, CT);
        drain();

        // clr while round_q is 5
        startBlock(1'b0, PT);
        for (int i = 0; i < 4; i++) tick();
        check("clr_rk_idx_r5", 128'(rk_idx), 128'd5);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        check("clr_in_ready", 128'(in_ready), 128'd1);
        check("clr_busy", 128'(busy), 128'd0);
        sawValid = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (out_valid) sawValid = 1'b1;
            tick();
        end
        check("clr_no_out_valid", 128'(sawValid), 128'd0);
        startBlock(1'b0, PT);
        waitDone(n);
        check("clr_next_latency", 128'(n), 128'd10);
        check("clr_next_block", out_block, CT);
        drain();

        // Asynchronous reset while round_q is 3
        startBlock(1'b0, PT);
        tick();
        tick();
        check("rst_rk_idx_r3", 128'(rk_idx), 128'd3);
        #2 rst_n = 1'b0;
        #1;
        checkResetOutputs("midrst");
        #2 rst_n = 1'b1;
        tick();
        startBlock(1'b0, PT);
        waitDone(n);
        check("postrst_latency", 128'(n), 128'd10);
        check("postrst_block", out_block, CT);
        drain();

`ifdef AES_CTRL_DECRYPT_EN
        // C.1 decrypt, walking round keys 10 down to 0
        in_mode = 1'b1;
        #1;
        check("dec_idle_rk_idx", 128'(rk_idx), 128'd10);
        startBlock(1'b1, CT);
        for (int r = 1; r <= 10; r++) begin
            check("dec_rk_idx", 128'(rk_idx), 128'(10 - r));
            check("dec_not_done", 128'(out_valid), 128'd0);
            tick();
        end
        check("dec_out_valid", 128'(out_valid), 128'd1);
        check("dec_out_block", out_block, PT);
        drain();
`else
        // Encrypt-only build ignores in_mode
        in_mode = 1'b1;
        #1;
        check("enconly_idle_rk_idx", 128'(rk_idx), 128'd0);
        startBlock(1'b1, PT);
        waitDone(n);
        check("enconly_latency", 128'(n), 128'd10);
        check("enconly_out_block", out_block, CT);
        drain();
`endif
        check("final_idle", 128'(in_ready), 128'd1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
